victim_cache: RTL
=================

# victim_cache

- Fully associative, write-back victim cache between the L2 cache and physical memory.
- Absorbs dirty lines evicted by L2 and serves later L2 read misses from those lines.
- Forwards read misses to pmem; drains its oldest entry to pmem when a new victim arrives and all entries are valid.
- Every entry holds the newest copy of its line relative to pmem.

## Interface

Parameters:
- VC_DEPTH, 4, number of entries; power of two, at least 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  L2 read request; held until mem_resp
- mem_write  in  1  L2 victim write; held until mem_resp
- mem_address  in  32  line address; bits [4:0] ignored
- mem_wdata  in  256  victim line from L2
- mem_rdata  out  256  line returned to L2; valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  pmem read request; held until pmem_resp
- pmem_write  out  1  pmem write request; held until pmem_resp
- pmem_address  out  32  line address to pmem, bits [4:0]=0
- pmem_wdata  out  256  line written to pmem
- pmem_rdata  in  256  line from pmem; valid with pmem_resp
- pmem_resp  in  1  pmem completion pulse

## Operation

- Storage: VC_DEPTH entries of vc_t {address, data} plus a valid bit each. All valid entries are dirty.
- Hit: valid entry with address[31:5] == mem_address[31:5]. At most one entry can hit.
- FIFO pointer (log2 VC_DEPTH bits) names the next replacement slot. It wraps from VC_DEPTH-1 to 0.
- States: IDLE, FETCH, DRAIN, RESP.
- IDLE, mem_read:
  - Hit: mem_rdata <= entry data; go to RESP. The entry is kept, and FIFO order is unchanged.
  - Miss: go to FETCH.
- IDLE, mem_write:
  - Hit: overwrite entry data in place; FIFO order unchanged; go to RESP.
  - Miss with a free slot: install {mem_address[31:5],5'b0, mem_wdata} in the lowest-index invalid slot; go to RESP.
  - Miss with all entries valid: go to DRAIN.
- mem_read and mem_write both high is illegal. If it happens, the write is serviced.
- FETCH: pmem_read=1, pmem_address = line-aligned mem_address. On pmem_resp, register pmem_rdata into mem_rdata and go to RESP. No allocation on a read miss.
- DRAIN: pmem_write=1, pmem_address/pmem_wdata come from the entry at the FIFO pointer. On pmem_resp:
  - Install the L2 victim in that slot.
  - Increment the FIFO pointer.
  - Go to RESP.
- Lines installed into a free slot do not move the pointer. After reset the pointer is 0, and slots fill 0..N-1 in pointer order.
- RESP: mem_resp=1 for exactly one cycle, then IDLE.

## Timing

- Reset values:
  - Outputs: mem_resp=0, mem_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - Internal: all valid bits=0, FIFO pointer=0, state=IDLE.
- rst_n assertion mid-transaction aborts it immediately. A pmem request drops in the same cycle, and no entry is written.
- Request sampled in IDLE on edge t:
  - Hit or free-slot install: mem_resp high in cycle t+1.
  - Miss that needs pmem: pmem request asserted from cycle t+1. mem_resp is high in the cycle after the edge that samples pmem_resp.
- pmem requests are registered outputs, held stable until pmem_resp.
- pmem_resp is ignored outside FETCH/DRAIN.
- IDLE always spends one cycle after RESP before sampling a new request. The upstream is expected to drop or renew its request in that cycle.
- No bypass. A write completes fully (mem_resp) before any following read can observe it.

## Structure

- In cache_hierarchy_types:
  - the existing vc_t serves as the entry type;
  - add vc_state_t enum {IDLE, FETCH, DRAIN, RESP};
  - add localparam VC_OFFSET_BITS = 5.
- Sub-module vc_match_array: combinational hit/index lookup, plus a first-free-slot priority encoder over the valid bits.
- Top level holds storage, the FIFO pointer, and the FSM.

## Test plan

- Reset, then read 0x0000_1000. Required: pmem_read with pmem_address 0x0000_1000; pmem returns line A after 3 cycles; mem_rdata=A with a 1-cycle mem_resp; no allocation, so a repeat read misses again.
- Write line B to 0x0000_2004, then read 0x0000_2000. Required: write resp at t+1; read hits with mem_rdata=B at t+1; no pmem activity.
- Write B then C to 0x0000_2000. Required: both hit in place; the following read returns C; FIFO pointer stays 0.
- Fill 4 entries at 0x100, 0x200, 0x300, 0x400, then write 0x500. Required: pmem_write to 0x100 with that entry's data; after pmem_resp, 0x500 occupies slot 0 and the pointer is 1; a 6th distinct write drains 0x200.
- Deassert rst_n during DRAIN. Required: pmem_write falls immediately; all entries invalid; the next read of 0x100 misses to pmem.
- Assert mem_read and mem_write together on 0x300. Required: serviced as a write.

Source files
------------

// File: rtl/cache_hierarchy_types.sv
// Shared types for the L2 / victim cache / pmem hierarchy.
// Holds the victim entry struct, FSM states and line offset width.
package cache_hierarchy_types;

  localparam int VC_OFFSET_BITS = 5;
  localparam int VC_TAG_BITS    = 32 - VC_OFFSET_BITS;

  typedef struct packed {
    logic [31:0]  address;
    logic [255:0] data;
  } vc_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    RESP
  } vc_state_t;

endpackage

// File: rtl/vc_match_array.sv
// Victim cache lookup: tag compare over valid entries plus lowest free slot.
// Ports: valid_i/tags_i (entry state), tag_i (probe) -> hit/free flags + indices.
module vc_match_array
  import cache_hierarchy_types::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = 2
) (
  input  logic [DEPTH-1:0]                  valid_i,
  input  logic [DEPTH-1:0][VC_TAG_BITS-1:0] tags_i,
  input  logic [VC_TAG_BITS-1:0]            tag_i,
  output logic                              hit_o,
  output logic [IW-1:0]                     hit_idx_o,
  output logic                              free_o,
  output logic [IW-1:0]                     free_idx_o
);

  always_comb begin
    hit_o      = 1'b0;
    hit_idx_o  = '0;
    free_o     = 1'b0;
    free_idx_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_i[i] && tags_i[i] == tag_i) begin
        hit_o     = 1'b1;
        hit_idx_o = IW'(i);
      end
    end
    // descending scan so the lowest invalid index wins
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        free_o     = 1'b1;
        free_idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/victim_cache.sv
// Fully associative write-back victim cache between L2 and pmem.
// Ports: mem_* (L2 side, held until mem_resp), pmem_* (memory side).
module victim_cache
  import cache_hierarchy_types::*;
#(
  parameter int VC_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [255:0] mem_wdata,
  output logic [255:0] mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int PW = $clog2(VC_DEPTH);

  vc_t                 entry_q [VC_DEPTH];
  logic [VC_DEPTH-1:0] valid_q;
  logic [PW-1:0]       ptr_q;
  vc_state_t           state_q;

  logic                mem_resp_q;
  logic [255:0]        mem_rdata_q;
  logic                pmem_read_q;
  logic                pmem_write_q;
  logic [31:0]         pmem_address_q;
  logic [255:0]        pmem_wdata_q;

  logic [VC_DEPTH-1:0][VC_TAG_BITS-1:0] tags;
  logic [31:0]   line_addr;
  vc_t           victim;
  logic          hit;
  logic          free;
  logic [PW-1:0] hit_idx;
  logic [PW-1:0] free_idx;
  logic          unused_offset;

  assign line_addr = {mem_address[31:VC_OFFSET_BITS],
                      {VC_OFFSET_BITS{1'b0}}};
  assign victim    = '{address: line_addr, data: mem_wdata};
  assign unused_offset = ^mem_address[VC_OFFSET_BITS-1:0];

  always_comb begin
    for (int i = 0; i < VC_DEPTH; i++) begin
      tags[i] = entry_q[i].address[31:VC_OFFSET_BITS];
    end
  end

  vc_match_array #(
    .DEPTH (VC_DEPTH),
    .IW    (PW)
  ) u_match (
    .valid_i    (valid_q),
    .tags_i     (tags),
    .tag_i      (mem_address[31:VC_OFFSET_BITS]),
    .hit_o      (hit),
    .hit_idx_o  (hit_idx),
    .free_o     (free),
    .free_idx_o (free_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      ptr_q          <= '0;
      mem_resp_q     <= 1'b0;
      mem_rdata_q    <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      for (int i = 0; i < VC_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          // write wins when both requests are raised
          if (mem_write) begin
            if (hit) begin
              entry_q[hit_idx].data <= mem_wdata;
              mem_resp_q <= 1'b1;
              state_q    <= RESP;
            end else if (free) begin
              entry_q[free_idx] <= victim;
              valid_q[free_idx] <= 1'b1;
              mem_resp_q <= 1'b1;
              state_q    <= RESP;
            end else begin
              pmem_write_q   <= 1'b1;
              pmem_address_q <= entry_q[ptr_q].address;
              pmem_wdata_q   <= entry_q[ptr_q].data;
              state_q        <= DRAIN;
            end
          end else if (mem_read) begin
            if (hit) begin
              mem_rdata_q <= entry_q[hit_idx].data;
              mem_resp_q  <= 1'b1;
              state_q     <= RESP;
            end else begin
              pmem_read_q    <= 1'b1;
              pmem_address_q <= line_addr;
              state_q        <= FETCH;
            end
          end
        end
        FETCH: begin
          if (pmem_resp) begin
            mem_rdata_q <= pmem_rdata;
            pmem_read_q <= 1'b0;
            mem_resp_q  <= 1'b1;
            state_q     <= RESP;
          end
        end
        DRAIN: begin
          if (pmem_resp) begin
            entry_q[ptr_q] <= victim;
            ptr_q          <= ptr_q + 1'b1;
            pmem_write_q   <= 1'b0;
            mem_resp_q     <= 1'b1;
            state_q        <= RESP;
          end
        end
        RESP: begin
          mem_resp_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_resp     = mem_resp_q;
  assign mem_rdata    = mem_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

endmodule
